fpu_add_pipe: RTL
=================

Name: fpu_add_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point adder/subtractor.
- Successor to the combinational ripple-carry FP adder: adds add/sub mode, round-to-nearest-even, special-value handling, status flags, and a valid/ready streaming interface.
- Fixed 3-cycle latency; one result per cycle when not stalled.
- Sits between the operand staging logic and the FPU result writeback path.

Parameters:
- M_size, 23, stored mantissa (fraction) width.
- E_size, 8, exponent width; bias = 2^(E_size-1)-1.
- total_size, M_size+E_size+1, operand/result width (derived; must not be overridden inconsistently).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and op valid this cycle
- in_ready  output  1  block accepts the operands this cycle
- A  input  total_size  operand A (sign, exponent, fraction)
- B  input  total_size  operand B
- op  input  1  0 = A+B, 1 = A-B (B sign inverted at stage 1)
- out_valid  output  1  SUM and flags valid
- out_ready  input  1  downstream accepts the result
- SUM  output  total_size  rounded result
- flag_ovf  output  1  finite result overflowed to infinity
- flag_unf  output  1  nonzero result flushed to zero
- flag_inv  output  1  invalid operation, NaN produced
- flag_inx  output  1  result inexact (any guard/round/sticky bit set)

Behaviour:
- Reset (async, rst_n=0): all stage valid bits, out_valid, SUM, and flags clear to 0; in_ready = 1 once released. Reset mid-operation discards all in-flight data; no partial result ever appears.
- Handshake:
  - Transfer occurs on in_valid && in_ready, and on out_valid && out_ready.
  - Global advance enable: adv = !out_valid || out_ready; in_ready = adv.
  - When adv = 0, all stage registers hold. SUM and flags stay stable while out_valid && !out_ready.
  - Bubbles (in_valid=0) propagate as invalid stages and collapse only at the output register.
- Stage 1 (unpack/align):
  - Effective sign of B = B[msb]^op.
  - Exponent 0 means zero: denormals are flushed to zero on input.
  - Implicit 1 is prepended for normal operands.
  - Operands are swapped so the larger magnitude (exponent, then fraction) is first.
  - Smaller mantissa is right-shifted by the exponent difference into an M_size+4 datapath (guard, round, sticky). Shift amounts >= M_size+3 yield only sticky = OR of the mantissa.
  - Special-case classification is registered alongside.
- Stage 2 (add):
  - Same effective signs: add. Otherwise subtract smaller from larger.
  - Result is never negative; sign = sign of the larger operand.
  - Exact zero from cancellation gives +0. Exception: (-0)+(-0) gives -0.
- Stage 3 (normalise/round):
  - Carry-out: shift right 1, OR the lost bit into sticky, exponent+1.
  - Otherwise: leading-zero count, then left shift and subtract from the exponent.
  - Round to nearest even: increment when G && (R||S||LSB). A rounding carry renormalises and bumps the exponent.
  - Exponent >= 2^E_size-1 gives ±infinity, flag_ovf=1, flag_inx=1.
  - Exponent <= 0 with nonzero value gives signed zero, flag_unf=1, flag_inx=1.
- Specials, in priority order:
  - Any NaN input, or inf + (-inf) effective: quiet NaN = 0, all-ones exponent, MSB fraction 1. flag_inv=1 only for the inf-inf case or a signalling NaN (fraction MSB 0).
  - Otherwise, any infinity: that infinity, with effective sign.
  - Zero operand: the other operand is returned exactly.
- Flags are per-result and travel with out_valid; they are not sticky.

Test Plan:
- A=0x3F800000, B=0x3F800000, op=0, out_ready=1 -> SUM=0x40000000 exactly 3 cycles after acceptance, all flags 0.
- A=0x3FC00000, B=0x3FC00000, op=1 -> SUM=0x00000000 (+0), flags 0; A=0x80000000, B=0x00000000, op=1 -> SUM=0x80000000.
- Rounding ties: 0x3F800000+0x33800000 -> 0x3F800000 with flag_inx=1; 0x3F800001+0x33800000 -> 0x3F800002 with flag_inx=1.
- Specials:
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000 with flag_inv=1.
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000 with flag_ovf=1, flag_inx=1.
  - 0x00800000 - 0x00800001 -> 0x80000000 with flag_unf=1.
- Backpressure: stream 5 back-to-back ops, hold out_ready=0 for 4 cycles after the first out_valid -> in_ready=0 during the stall, SUM held stable, all 5 results delivered in order with none lost or duplicated.
- Assert rst_n=0 asynchronously (mid-cycle) while 3 ops are in flight -> out_valid drops immediately; after release, no stale result appears and the next op completes with 3-cycle latency.

Source files
------------

// File: rtl/fpu_add_pipe.sv
// fpu_add_pipe: 3-stage pipelined floating-point adder/subtractor with
// round-to-nearest-even, flush-to-zero denormals and valid/ready streaming.
module fpu_add_pipe #(
  parameter int M_size     = 23,
  parameter int E_size     = 8,
  parameter int total_size = M_size + E_size + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [total_size-1:0] A,
  input  logic [total_size-1:0] B,
  input  logic                  op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [total_size-1:0] SUM,
  output logic                  flag_ovf,
  output logic                  flag_unf,
  output logic                  flag_inv,
  output logic                  flag_inx
);

  localparam int W       = M_size + 4;
  localparam int EW      = E_size + 2;
  localparam int MR      = M_size + 2;
  localparam int LZW     = $clog2(W + 1);
  localparam int EXP_INF = (1 << E_size) - 1;
  localparam logic [E_size-1:0]     EMAX = '1;
  localparam logic [total_size-1:0] QNAN = {1'b0, EMAX, 1'b1, {(M_size-1){1'b0}}};

  function automatic logic [LZW-1:0] lead_zeros(input logic [W-1:0] v);
    logic [LZW-1:0] n;
    n = LZW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (v[i]) n = LZW'(W - 1 - i);
    end
    return n;
  endfunction

  logic adv;

  logic                  s1_valid_q, s1_sign_q, s1_sub_q, s1_spec_q, s1_inv_q;
  logic [E_size-1:0]     s1_exp_q;
  logic [W-1:0]          s1_ml_q, s1_ms_q;
  logic [total_size-1:0] s1_res_q;

  logic                  s2_valid_q, s2_sign_q, s2_spec_q, s2_inv_q;
  logic [E_size-1:0]     s2_exp_q;
  logic [W:0]            s2_sum_q;
  logic [total_size-1:0] s2_res_q;

  logic                  out_valid_q, ovf_q, unf_q, inv_q, inx_q;
  logic [total_size-1:0] sum_q;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign SUM       = sum_q;
  assign flag_ovf  = ovf_q;
  assign flag_unf  = unf_q;
  assign flag_inv  = inv_q;
  assign flag_inx  = inx_q;

  // ---------------- Stage 1: unpack, classify, swap, align ----------------
  logic              sa, sb;
  logic [E_size-1:0] ea, eb;
  logic [M_size-1:0] fa, fb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, inf_clash;

  assign sa        = A[total_size-1];
  assign sb        = B[total_size-1] ^ op;
  assign ea        = A[total_size-2:M_size];
  assign eb        = B[total_size-2:M_size];
  assign fa        = A[M_size-1:0];
  assign fb        = B[M_size-1:0];
  assign a_zero    = (ea == '0);
  assign b_zero    = (eb == '0);
  assign a_inf     = (ea == EMAX) && (fa == '0);
  assign b_inf     = (eb == EMAX) && (fb == '0);
  assign a_nan     = (ea == EMAX) && (fa != '0);
  assign b_nan     = (eb == EMAX) && (fb != '0);
  assign a_snan    = a_nan && !fa[M_size-1];
  assign b_snan    = b_nan && !fb[M_size-1];
  assign inf_clash = a_inf && b_inf && (sa != sb);

  logic                  a_ge, s1_sign_d, s1_sub_d, s1_spec_d, s1_inv_d;
  logic [W-1:0]          ma, mb, ml, ms, ms_al;
  logic [E_size-1:0]     el, es, ediff;
  logic [2*W-1:0]        wide;
  logic [total_size-1:0] s1_res_d;

  always_comb begin
    a_ge      = {ea, fa} >= {eb, fb};
    ma        = a_zero ? '0 : {1'b1, fa, 3'b000};
    mb        = b_zero ? '0 : {1'b1, fb, 3'b000};
    ml        = a_ge ? ma : mb;
    ms        = a_ge ? mb : ma;
    el        = a_ge ? ea : eb;
    es        = a_ge ? eb : ea;
    s1_sign_d = a_ge ? sa : sb;
    s1_sub_d  = sa ^ sb;
    ediff     = el - es;
    // Upper half is the aligned mantissa, lower half collects the shifted-out bits.
    wide      = {ms, {W{1'b0}}} >> ediff;
    if (32'(ediff) >= 32'(M_size + 3)) begin
      ms_al = {{(W-1){1'b0}}, |ms};
    end else begin
      ms_al = {wide[2*W-1:W+1], wide[W] | (|wide[W-1:0])};
    end
  end

  always_comb begin
    s1_spec_d = 1'b0;
    s1_inv_d  = 1'b0;
    s1_res_d  = '0;
    if (a_nan || b_nan || inf_clash) begin
      s1_spec_d = 1'b1;
      s1_res_d  = QNAN;
      s1_inv_d  = a_snan || b_snan || inf_clash;
    end else if (a_inf) begin
      s1_spec_d = 1'b1;
      s1_res_d  = {sa, EMAX, {M_size{1'b0}}};
    end else if (b_inf) begin
      s1_spec_d = 1'b1;
      s1_res_d  = {sb, EMAX, {M_size{1'b0}}};
    end else if (a_zero && b_zero) begin
      s1_spec_d = 1'b1;
      s1_res_d  = {sa & sb, {(total_size-1){1'b0}}};
    end else if (b_zero) begin
      s1_spec_d = 1'b1;
      s1_res_d  = A;
    end else if (a_zero) begin
      s1_spec_d = 1'b1;
      s1_res_d  = {sb, B[total_size-2:0]};
    end
  end

  // ---------------- Stage 2: magnitude add / subtract ----------------
  logic [W:0] s2_sum_d;
  logic       s2_sign_d;

  always_comb begin
    if (s1_sub_q) s2_sum_d = {1'b0, s1_ml_q} - {1'b0, s1_ms_q};
    else          s2_sum_d = {1'b0, s1_ml_q} + {1'b0, s1_ms_q};
    s2_sign_d = (s1_sub_q && (s2_sum_d == '0)) ? 1'b0 : s1_sign_q;
  end

  // ---------------- Stage 3: normalise, round, pack ----------------
  logic [LZW-1:0]        lz;
  logic [W-1:0]          mn;
  logic [EW-1:0]         e_norm, e_rnd;
  logic                  inc, inx;
  logic [MR-1:0]         mr;
  logic [M_size-1:0]     frac_r;
  logic [total_size-1:0] res_d;
  logic                  ovf_d, unf_d, inv_d, inx_d;

  always_comb begin
    lz     = '0;
    mn     = '0;
    e_norm = '0;
    res_d  = '0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    inv_d  = 1'b0;
    inx_d  = 1'b0;
    if (s2_sum_q[W]) begin
      mn     = {s2_sum_q[W:2], s2_sum_q[1] | s2_sum_q[0]};
      e_norm = {2'b00, s2_exp_q} + EW'(1);
    end else begin
      lz     = lead_zeros(s2_sum_q[W-1:0]);
      mn     = s2_sum_q[W-1:0] << lz;
      e_norm = {2'b00, s2_exp_q} - EW'(lz);
    end
    inc    = mn[2] & (mn[1] | mn[0] | mn[3]);
    inx    = mn[2] | mn[1] | mn[0];
    mr     = {1'b0, mn[W-1:3]} + MR'(inc);
    // A rounding carry leaves 10..0, so the fraction is the shifted-down zero field.
    frac_r = mr[MR-1] ? mr[M_size:1] : mr[M_size-1:0];
    e_rnd  = e_norm + EW'(mr[MR-1]);

    if (s2_spec_q) begin
      res_d = s2_res_q;
      inv_d = s2_inv_q;
    end else if (s2_sum_q == '0) begin
      res_d = {s2_sign_q, {(total_size-1){1'b0}}};
    end else if ($signed(e_rnd) >= $signed(EW'(EXP_INF))) begin
      res_d = {s2_sign_q, EMAX, {M_size{1'b0}}};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if ($signed(e_rnd) <= $signed(EW'(0))) begin
      res_d = {s2_sign_q, {(total_size-1){1'b0}}};
      unf_d = 1'b1;
      inx_d = 1'b1;
    end else begin
      res_d = {s2_sign_q, e_rnd[E_size-1:0], frac_r};
      inx_d = inx;
    end
  end

  // ---------------- Pipeline registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_sub_q    <= 1'b0;
      s1_spec_q   <= 1'b0;
      s1_inv_q    <= 1'b0;
      s1_exp_q    <= '0;
      s1_ml_q     <= '0;
      s1_ms_q     <= '0;
      s1_res_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_spec_q   <= 1'b0;
      s2_inv_q    <= 1'b0;
      s2_exp_q    <= '0;
      s2_sum_q    <= '0;
      s2_res_q    <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inv_q       <= 1'b0;
      inx_q       <= 1'b0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      s1_sign_q   <= s1_sign_d;
      s1_sub_q    <= s1_sub_d;
      s1_spec_q   <= s1_spec_d;
      s1_inv_q    <= s1_inv_d;
      s1_exp_q    <= el;
      s1_ml_q     <= ml;
      s1_ms_q     <= ms_al;
      s1_res_q    <= s1_res_d;
      s2_valid_q  <= s1_valid_q;
      s2_sign_q   <= s2_sign_d;
      s2_spec_q   <= s1_spec_q;
      s2_inv_q    <= s1_inv_q;
      s2_exp_q    <= s1_exp_q;
      s2_sum_q    <= s2_sum_d;
      s2_res_q    <= s1_res_q;
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        sum_q <= res_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
        inv_q <= inv_d;
        inx_q <= inx_d;
      end
    end
  end

endmodule
